sort_loader: RTL and testbench

Upstream feeder for the 8-input bitonic sorter (`full_CAE`). It accepts a serial stream of DATA_W-bit words over a valid/ready handshake and assembles them into 8-word blocks. Short blocks are padded so that the padding sorts to the tail. Completed blocks are presented in parallel with their sort direction. Two banks (ping-pong) let block N+1 fill while block N waits for the sorter. The sorter's `enable` is driven from this block's output handshake (`blk_valid & blk_ready`).

---
 rtl/sort_loader.sv | 118 +++++++++++
 tb/tb_sort_loader.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/sort_loader.sv
// Serial-to-block loader for the 8-input bitonic sorter.
// Two ping-pong banks: one fills while the other waits for the sorter.
module sort_loader #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  input  logic              in_dir,
  output logic              in_ready,
  output logic [DATA_W-1:0] w1,
  output logic [DATA_W-1:0] w2,
  output logic [DATA_W-1:0] w3,
  output logic [DATA_W-1:0] w4,
  output logic [DATA_W-1:0] w5,
  output logic [DATA_W-1:0] w6,
  output logic [DATA_W-1:0] w7,
  output logic [DATA_W-1:0] w8,
  output logic              blk_dir,
  output logic [3:0]        blk_count,
  output logic              blk_valid,
  input  logic              blk_ready
);

  logic [DATA_W-1:0] mem_q [2][8];
  logic [DATA_W-1:0] mem_d [2][8];
  logic [1:0]        dir_q, dir_d;
  logic [1:0]        full_q, full_d;
  logic [3:0]        cnt_q [2];
  logic [3:0]        cnt_d [2];
  logic              wr_sel_q, wr_sel_d;
  logic              rd_sel_q, rd_sel_d;
  logic [2:0]        idx_q, idx_d;

  logic              accept;
  logic              rel;
  logic              done;
  logic              bank_dir;
  logic [DATA_W-1:0] pad;

  assign in_ready  = !full_q[wr_sel_q];
  assign blk_valid = full_q[rd_sel_q];
  assign blk_dir   = dir_q[rd_sel_q];
  assign blk_count = cnt_q[rd_sel_q];
  assign w1 = mem_q[rd_sel_q][0];
  assign w2 = mem_q[rd_sel_q][1];
  assign w3 = mem_q[rd_sel_q][2];
  assign w4 = mem_q[rd_sel_q][3];
  assign w5 = mem_q[rd_sel_q][4];
  assign w6 = mem_q[rd_sel_q][5];
  assign w7 = mem_q[rd_sel_q][6];
  assign w8 = mem_q[rd_sel_q][7];

  always_comb begin
    mem_d    = mem_q;
    dir_d    = dir_q;
    full_d   = full_q;
    cnt_d    = cnt_q;
    wr_sel_d = wr_sel_q;
    rd_sel_d = rd_sel_q;
    idx_d    = idx_q;
    accept   = in_valid & in_ready;
    rel      = blk_valid & blk_ready;
    done     = (idx_q == 3'd7) | in_last;
    // first word's direction is not yet registered
    bank_dir = (idx_q == 3'd0) ? in_dir : dir_q[wr_sel_q];
    pad      = {DATA_W{bank_dir}};

    if (accept) begin
      mem_d[wr_sel_q][idx_q] = in_data;
      if (idx_q == 3'd0)
        dir_d[wr_sel_q] = in_dir;
      if (done) begin
        full_d[wr_sel_q] = 1'b1;
        cnt_d[wr_sel_q]  = {1'b0, idx_q} + 4'd1;
        for (int i = 1; i < 8; i++)
          if (3'(i) > idx_q)
            mem_d[wr_sel_q][i] = pad;
        idx_d    = 3'd0;
        wr_sel_d = ~wr_sel_q;
      end else begin
        idx_d = idx_q + 3'd1;
      end
    end

    // a release always targets the other bank when both fire
    if (rel) begin
      full_d[rd_sel_q] = 1'b0;
      rd_sel_d         = ~rd_sel_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < 8; i++)
          mem_q[b][i] <= '0;
        cnt_q[b] <= 4'd0;
      end
      dir_q    <= 2'b00;
      full_q   <= 2'b00;
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
      idx_q    <= 3'd0;
    end else begin
      mem_q    <= mem_d;
      cnt_q    <= cnt_d;
      dir_q    <= dir_d;
      full_q   <= full_d;
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
      idx_q    <= idx_d;
    end
  end

endmodule

// File: tb/tb_sort_loader.sv
// Directed bench for sort_loader with a block scoreboard.
// Expected blocks are built from the driven words and popped on release.
module tb_sort_loader;

  typedef struct packed {
    logic [7:0][31:0] w;
    logic             dir;
    logic [3:0]       cnt;
  } blk_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_data;
  logic        in_valid, in_last, in_dir;
  logic        in_ready;
  logic [31:0] w1, w2, w3, w4, w5, w6, w7, w8;
  logic        blk_dir;
  logic [3:0]  blk_count;
  logic        blk_valid;
  logic        blk_ready;

  int n_cmp = 0;
  int n_err = 0;

  blk_t             sb[$];
  logic [7:0][31:0] mw;
  logic             mdir;
  int               mi;

  sort_loader #(.DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_dir(in_dir),
    .in_ready(in_ready),
    .w1(w1), .w2(w2), .w3(w3), .w4(w4),
    .w5(w5), .w6(w6), .w7(w7), .w8(w8),
    .blk_dir(blk_dir), .blk_count(blk_count),
    .blk_valid(blk_valid), .blk_ready(blk_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_pop();
    blk_t e;
    logic [7:0][31:0] o;
    if (sb.size() == 0) begin
      chk("unexpected_blk", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    o = {w8, w7, w6, w5, w4, w3, w2, w1};
    for (int i = 0; i < 8; i++)
      chk($sformatf("blk_w%0d", i + 1), o[i], e.w[i]);
    chk("blk_dir", {31'd0, blk_dir}, {31'd0, e.dir});
    chk("blk_count", {28'd0, blk_count}, {28'd0, e.cnt});
  endtask

  task automatic model_accept(input logic [31:0] d,
                              input logic l,
                              input logic dr);
    blk_t b;
    if (mi == 0) mdir = dr;
    mw[mi] = d;
    if (mi == 7 || l) begin
      for (int i = mi + 1; i < 8; i++)
        mw[i] = mdir ? 32'hFFFF_FFFF : 32'h0;
      b.w   = mw;
      b.dir = mdir;
      b.cnt = 4'(mi + 1);
      sb.push_back(b);
      mi = 0;
    end else begin
      mi++;
    end
  endtask

  // one clock cycle: drive, observe handshakes, advance to next negedge
  task automatic step(input logic v, input logic [31:0] d,
                      input logic l, input logic dr,
                      input logic br);
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    in_dir    = dr;
    blk_ready = br;
    #1;
    if (blk_valid && blk_ready) check_pop();
    if (in_valid && in_ready) model_accept(d, l, dr);
    @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_blk_valid"}, {31'd0, blk_valid}, 32'd0);
    chk({tag, "_w1"}, w1, 32'd0);
    chk({tag, "_w8"}, w8, 32'd0);
    chk({tag, "_blk_dir"}, {31'd0, blk_dir}, 32'd0);
    chk({tag, "_blk_count"}, {28'd0, blk_count}, 32'd0);
  endtask

  initial begin
    logic [31:0] full_vals [8];
    full_vals = '{1, 4, 5, 7, 0, 2, 3, 6};
    mi = 0; mdir = 1'b0; mw = '0;
    reset = 1'b1;
    in_valid = 0; in_data = 0; in_last = 0;
    in_dir = 0; blk_ready = 0;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    reset = 1'b0;
    @(negedge clk);

    // full block, back-to-back with a following short block
    for (int i = 0; i < 8; i++) begin
      chk("full_in_ready", {31'd0, in_ready}, 32'd1);
      step(1, full_vals[i], 0, 1, 1);
    end
    chk("full_latency_valid", {31'd0, blk_valid}, 32'd1);

    // short ascending; mid-block dir change is ignored
    step(1, 20, 0, 1, 1);
    step(1, 24, 0, 0, 1);
    step(1, 26, 1, 0, 1);
    chk("short_up_valid", {31'd0, blk_valid}, 32'd1);
    step(0, 0, 0, 0, 1);

    // short descending
    step(1, 20, 0, 0, 1);
    step(1, 24, 0, 1, 1);
    step(1, 26, 1, 1, 1);
    step(0, 0, 0, 0, 1);
    chk("idle_valid", {31'd0, blk_valid}, 32'd0);

    // backpressure: two banks stored, word 16 held
    for (int i = 0; i < 17; i++) begin
      chk("bp_in_ready", {31'd0, in_ready}, (i < 16) ? 32'd1 : 32'd0);
      step(1, 32'(i), 0, 0, 0);
    end
    chk("bp_valid", {31'd0, blk_valid}, 32'd1);
    chk("bp_hold_w1", w1, 32'd0);
    step(1, 16, 0, 0, 1);
    chk("bp_rel_in_ready", {31'd0, in_ready}, 32'd1);
    chk("bp_next_valid", {31'd0, blk_valid}, 32'd1);
    chk("bp_next_w1", w1, 32'd8);
    step(1, 16, 0, 0, 0);
    step(0, 0, 0, 0, 1);

    // reset mid-block, asserted between edges
    for (int i = 17; i < 21; i++)
      step(1, 32'(i), 0, 0, 0);
    chk("pre_rst_w1", w1, 32'd16);
    #3;
    reset = 1'b1;
    #1;
    chk_reset_vals("async_rst");
    sb.delete();
    mi = 0;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 8; i++)
      step(1, 32'(100 + i), 0, 1, 1);
    step(0, 0, 0, 0, 1);

    // completion into one bank while the other is released
    for (int i = 0; i < 8; i++)
      step(1, 32'(200 + i), 0, 1, 0);
    for (int i = 0; i < 7; i++)
      step(1, 32'(300 + i), 0, 0, 0);
    step(1, 307, 0, 0, 1);
    chk("sim_in_ready", {31'd0, in_ready}, 32'd1);
    chk("sim_valid", {31'd0, blk_valid}, 32'd1);
    chk("sim_w1", w1, 32'd300);
    step(0, 0, 0, 0, 1);
    chk("end_valid", {31'd0, blk_valid}, 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
